// File: rtl/knightrider_sequencer.sv
// knightrider_sequencer
//   Sweeps a single lit LED back and forth across NUM_LEDS outputs, pausing
//   HOLD_STEPS steps at each end. One step is taken every 2^speed_sel rising
//   edges of slow_clk. slow_clk is only sampled as a tick source and is never
//   used as a clock.
//
//   Optional build macro: KNIGHTRIDER_TRAIL_EN
//     When defined, the previously lit position stays lit while sweeping,
//     which gives a two-LED trail. The trail is cleared at the ends (hold)
//     and in idle.
//
// Ports
//   clk        in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   slow_clk   in   divided clock level, synchronous to clk
//   run        in   1 = sweep, 0 = idle
//   speed_sel  in   [1:0] slow_clk rising edges per step = 2^speed_sel
//   led        out  [NUM_LEDS-1:0] active-low LED drive
//   pos        out  [POS_W-1:0] current lit position
//   dir        out  0 = moving up, 1 = moving down
//   step       out  one-cycle pulse when a new pos/state becomes visible
//
// State      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | run low, all LEDs off, counters cleared
// S_UP       | moving toward NUM_LEDS-1
// S_HOLD_TOP | paused at NUM_LEDS-1, counting hold steps
// S_DOWN     | moving toward 0
// S_HOLD_BOT | paused at 0, counting hold steps
module knightrider_sequencer #(
  parameter int NUM_LEDS   = 6,
  parameter int HOLD_STEPS = 2,
  parameter int POS_W      = 4
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                slow_clk,
  input  logic                run,
  input  logic [1:0]          speed_sel,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                dir,
  output logic                step
);

  typedef enum logic [2:0] {
    S_IDLE, S_UP, S_HOLD_TOP, S_DOWN, S_HOLD_BOT
  } state_t;

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [POS_W-1:0] P_TOP     = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] P_NTOP    = POS_W'(NUM_LEDS - 2);

  state_t              r_state;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir;
  logic                r_step;
  logic                r_slow_clk_d;
  logic [2:0]          r_tick_cnt;
  logic [HW-1:0]       r_hold_cnt;

  logic                w_tick;
  logic [3:0]          w_thr;
  logic                w_step_evt;
  logic [NUM_LEDS-1:0] w_led;

  function automatic logic [NUM_LEDS-1:0] f_led(input logic [POS_W-1:0] p);
    f_led = ~(NUM_LEDS'(1) << p);
  endfunction

  assign w_tick = slow_clk & ~r_slow_clk_d;
  assign w_thr  = (4'd1 << speed_sel) - 4'd1;
  // >= rather than == so that lowering speed_sel mid-count steps on the next
  // tick instead of wrapping the counter.
  assign w_step_evt = run && (r_state != S_IDLE) && w_tick &&
                      ({1'b0, r_tick_cnt} >= w_thr);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_pos        <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_slow_clk_d <= 1'b0;
      r_tick_cnt   <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_slow_clk_d <= slow_clk;
      r_step       <= 1'b0;
      if (!run) begin
        // run low beats any tick arriving on the same edge
        r_state    <= S_IDLE;
        r_pos      <= '0;
        r_dir      <= 1'b0;
        r_tick_cnt <= '0;
        r_hold_cnt <= '0;
      end else if (r_state == S_IDLE) begin
        r_state    <= S_UP;
        r_pos      <= '0;
        r_dir      <= 1'b0;
        r_tick_cnt <= '0;
      end else if (w_step_evt) begin
        r_tick_cnt <= '0;
        r_step     <= 1'b1;
        case (r_state)
          S_UP: begin
            if (r_pos != P_TOP) begin
              r_pos <= r_pos + 1'b1;
            end else if (HOLD_STEPS > 0) begin
              r_state    <= S_HOLD_TOP;
              r_hold_cnt <= '0;
              r_dir      <= 1'b1;
            end else begin
              r_state <= S_DOWN;
              r_pos   <= P_NTOP;
              r_dir   <= 1'b1;
            end
          end
          S_HOLD_TOP: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state <= S_DOWN;
              r_pos   <= P_NTOP;
              r_dir   <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          S_DOWN: begin
            if (r_pos != '0) begin
              r_pos <= r_pos - 1'b1;
            end else if (HOLD_STEPS > 0) begin
              r_state    <= S_HOLD_BOT;
              r_hold_cnt <= '0;
              r_dir      <= 1'b0;
            end else begin
              r_state <= S_UP;
              r_pos   <= POS_W'(1);
              r_dir   <= 1'b0;
            end
          end
          S_HOLD_BOT: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state <= S_UP;
              r_pos   <= POS_W'(1);
              r_dir   <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 3'd1;
      end
    end
  end

`ifdef KNIGHTRIDER_TRAIL_EN
  logic [POS_W-1:0] r_trail_pos;
  logic             r_trail_vld;
  logic             w_enter_hold;
  logic             w_pos_move;

  assign w_enter_hold = (HOLD_STEPS > 0) &&
                        (((r_state == S_UP)   && (r_pos == P_TOP)) ||
                         ((r_state == S_DOWN) && (r_pos == '0)));
  // In a hold state pos only moves on the final hold step.
  assign w_pos_move   = !w_enter_hold &&
                        ((r_state == S_UP) || (r_state == S_DOWN) ||
                         (r_hold_cnt == HOLD_LAST));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_trail_pos <= '0;
      r_trail_vld <= 1'b0;
    end else if (!run) begin
      r_trail_pos <= '0;
      r_trail_vld <= 1'b0;
    end else if (w_step_evt) begin
      if (w_enter_hold) begin
        r_trail_pos <= '0;
        r_trail_vld <= 1'b0;
      end else if (w_pos_move) begin
        r_trail_pos <= r_pos;
        r_trail_vld <= 1'b1;
      end
    end
  end
`endif

  // led is a pure decode of registered state, so it changes on the same
  // edge as pos.
  always_comb begin
    w_led = '1;
    if (r_state != S_IDLE) w_led = f_led(r_pos);
`ifdef KNIGHTRIDER_TRAIL_EN
    if (r_trail_vld) w_led = w_led & f_led(r_trail_pos);
`endif
  end

  assign led  = w_led;
  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;

endmodule

// File: doc/knightrider_sequencer.md
KNIGHTRIDER_SEQUENCER -- requirements
Module: knightrider_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 6: number of LEDs swept; legal range 2..16.
REQ-002 Parameter HOLD_STEPS, default 2: number of steps spent paused at each end; 0 means no pause.
REQ-003 Parameter POS_W, default 4: width of pos; must satisfy 2^POS_W >= NUM_LEDS.
REQ-004 clk  input  1  system clock; all logic is rising-edge clocked.
REQ-005 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-006 slow_clk  input  1  divided clock level, synchronous to clk; used only as a tick source, never as a clock.
REQ-007 run  input  1  level; 1 = sweep, 0 = idle.
REQ-008 speed_sel  input  2  slow_clk rising edges per step = 2^speed_sel (1, 2, 4 or 8).
REQ-009 led  output  NUM_LEDS  LED drive, active-low (0 = lit).
REQ-010 pos  output  POS_W  current lit position, 0..NUM_LEDS-1.
REQ-011 dir  output  1  0 = moving up (toward NUM_LEDS-1), 1 = moving down.
REQ-012 step  output  1  single-cycle pulse, high in the cycle in which a new pos/state first becomes visible.

Function
REQ-013 tick SHALL be defined as slow_clk & ~slow_clk_d, where slow_clk_d is slow_clk registered once in clk.
REQ-014 A tick counter SHALL count ticks while run=1; a step occurs at the edge where tick=1 and tick_cnt >= 2^speed_sel - 1; that edge clears tick_cnt.
REQ-015 The comparison SHALL use >=, so lowering speed_sel mid-count causes a step on the next tick with no wrap-around; speed_sel is sampled at every tick.
REQ-016 States SHALL be IDLE, UP, HOLD_TOP, DOWN, HOLD_BOT.
REQ-017 IDLE: led all 1s, pos=0, dir=0, tick_cnt=0; when run=1, go to UP at the next edge with pos=0 (LED0 lit from the following cycle), and step=0.
REQ-018 UP, on step: if pos < NUM_LEDS-1, pos+1; else go to HOLD_TOP (hold_cnt=0) if HOLD_STEPS>0, else go to DOWN with pos=NUM_LEDS-2, dir=1.
REQ-019 HOLD_TOP, on step: pos unchanged, hold_cnt+1; on the step where hold_cnt = HOLD_STEPS-1, go to DOWN with pos=NUM_LEDS-2, dir=1.
REQ-020 DOWN and HOLD_BOT SHALL mirror REQ-018/019: at pos 0, go to HOLD_BOT or to UP with pos=1, dir=0.
REQ-021 dir SHALL be 0 in UP/HOLD_BOT/IDLE and 1 in DOWN/HOLD_TOP.
REQ-022 Outside IDLE, led[pos]=0 and all other bits are 1, except as modified by REQ-028.
REQ-023 step SHALL be registered and asserted for exactly one cycle per step event, including hold steps.
REQ-024 If run goes to 0 in any state, the block SHALL enter IDLE at the next edge, with outputs per REQ-017 and any pending step discarded.
REQ-025 If a tick and the falling edge of run coincide, IDLE wins and step stays 0.

Reset
REQ-026 While sys_rst_n=0: state=IDLE, led all 1s, pos=0, dir=0, step=0, tick_cnt=0, hold_cnt=0, slow_clk_d=0, trail state cleared.
REQ-027 Reset assertion mid-sweep SHALL take effect immediately, and the first tick after release SHALL be counted normally.

Configuration
REQ-028 With macro KNIGHTRIDER_TRAIL_EN defined: the block SHALL keep trail_pos (the previous pos, updated on each pos change) and also drive led[trail_pos]=0 in UP/DOWN; the trail is cleared on entry to HOLD_TOP, HOLD_BOT and IDLE. Without the macro: exactly one LED is lit outside IDLE and no trail register exists.

Verification
REQ-029 Reset release, run=1, speed_sel=0, NUM_LEDS=6, HOLD_STEPS=2, slow_clk toggling -> pos follows 0,1,2,3,4,5,5,5,4,3,2,1,0,0,0,1, with one step pulse per transition or hold.
REQ-030 speed_sel=3 -> exactly 8 slow_clk rising edges between consecutive step pulses; switching to speed_sel=0 with tick_cnt=5 -> step on the next tick.
REQ-031 HOLD_STEPS=0 -> pos follows 0..5,4,3..0,1 with no repeated values; dir toggles on the same edge as the pos change at each end.
REQ-032 run dropped at pos=3 during DOWN -> next cycle led=6'b111111, pos=0, dir=0; run raised again -> LED0 lit, next step gives pos=1.
REQ-033 KNIGHTRIDER_TRAIL_EN defined, UP at pos=2 -> led=6'b111001; in HOLD_TOP -> led=6'b011111.
REQ-034 sys_rst_n pulsed low mid-HOLD_TOP -> all outputs at reset values during the pulse; after release, sweep restarts from IDLE.
